// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and command sequencer for the 32-bit SRAM word array.
// Issues registered array commands and returns read data on the requesting port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no command issued last cycle
// ST_RD   | read command issued last cycle
// ST_WR   | write command issued last cycle; reads masked (turnaround)
module sram_port_arbiter #(
    parameter int N_addr = 11,
    parameter int N_data = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [N_addr-1:0] a_addr,
    input  logic [N_data-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [N_data-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [N_addr-1:0] b_addr,
    input  logic [N_data-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [N_data-1:0] b_rdata,
    output logic [N_addr-1:0] sram_addr,
    output logic [N_data-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [N_data-1:0] sram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;   // 1 = port B granted last
    logic [N_addr-1:0] sram_addr_q, sram_addr_d;
    logic [N_data-1:0] sram_din_q, sram_din_d;
    logic              sram_write_en_q, sram_write_en_d;
    logic              sram_sense_en_q, sram_sense_en_d;
    logic [RD_LAT:0]   pvld_q, pvld_d;
    logic [RD_LAT:0]   pport_q, pport_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [N_data-1:0] a_rdata_q, a_rdata_d;
    logic [N_data-1:0] b_rdata_q, b_rdata_d;

    logic a_elig, b_elig, gnt_any, gnt_we, rd_gnt;

    always_comb begin
        a_elig = a_req & (a_we | (state_q != ST_WR));
        b_elig = b_req & (b_we | (state_q != ST_WR));

        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_elig && b_elig) begin
                a_gnt = last_gnt_q;
                b_gnt = ~last_gnt_q;
            end else begin
                a_gnt = a_elig;
                b_gnt = b_elig;
            end
        end

        gnt_any = a_gnt | b_gnt;
        gnt_we  = a_gnt ? a_we : b_we;
        rd_gnt  = gnt_any & ~gnt_we;

        last_gnt_d = last_gnt_q;
        if (gnt_any) last_gnt_d = b_gnt;

        state_d = ST_IDLE;
        if (gnt_any) state_d = gnt_we ? ST_WR : ST_RD;

        // Address and data only move on a grant so idle cycles hold them.
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        if (gnt_any) begin
            sram_addr_d = a_gnt ? a_addr : b_addr;
            if (gnt_we) sram_din_d = a_gnt ? a_wdata : b_wdata;
        end
        sram_write_en_d = gnt_any & gnt_we;
        sram_sense_en_d = ~rd_gnt;

        pvld_d  = {pvld_q[RD_LAT-1:0], rd_gnt};
        pport_d = {pport_q[RD_LAT-1:0], b_gnt};

        // Final pipeline stage lines up with valid array output.
        a_rvalid_d = pvld_q[RD_LAT] & ~pport_q[RD_LAT];
        b_rvalid_d = pvld_q[RD_LAT] & pport_q[RD_LAT];
        a_rdata_d  = a_rvalid_d ? sram_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? sram_dout : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            last_gnt_q      <= 1'b1;
            sram_addr_q     <= '0;
            sram_din_q      <= '0;
            sram_write_en_q <= 1'b0;
            sram_sense_en_q <= 1'b1;
            pvld_q          <= '0;
            pport_q         <= '0;
            a_rvalid_q      <= 1'b0;
            b_rvalid_q      <= 1'b0;
            a_rdata_q       <= '0;
            b_rdata_q       <= '0;
        end else begin
            state_q         <= state_d;
            last_gnt_q      <= last_gnt_d;
            sram_addr_q     <= sram_addr_d;
            sram_din_q      <= sram_din_d;
            sram_write_en_q <= sram_write_en_d;
            sram_sense_en_q <= sram_sense_en_d;
            pvld_q          <= pvld_d;
            pport_q         <= pport_d;
            a_rvalid_q      <= a_rvalid_d;
            b_rvalid_q      <= b_rvalid_d;
            a_rdata_q       <= a_rdata_d;
            b_rdata_q       <= b_rdata_d;
        end
    end

    assign sram_addr     = sram_addr_q;
    assign sram_din      = sram_din_q;
    assign sram_write_en = sram_write_en_q;
    assign sram_sense_en = sram_sense_en_q;
    assign a_rvalid      = a_rvalid_q;
    assign b_rvalid      = b_rvalid_q;
    assign a_rdata       = a_rdata_q;
    assign b_rdata       = b_rdata_q;
    assign busy          = |pvld_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a cycle table on the default build plus
// reset, mid-read reset and RD_LAT=3 sequences; behavioural SRAM models per instance.
module tb_sram_port_arbiter;

    localparam logic [1:0] CI = 2'd0, CR = 2'd1, CW = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default build
    logic        a_req, a_we, b_req, b_we;
    logic [10:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
    logic [31:0] a_rdata, b_rdata;
    logic [10:0] s0_addr;
    logic [31:0] s0_din, dout0;
    logic        s0_we, s0_se;

    // RD_LAT = 3 build, port A only
    logic        r3_req;
    logic [10:0] r3_addr;
    logic        r3_a_gnt, r3_b_gnt, r3_a_rvalid, r3_b_rvalid, r3_busy;
    logic [31:0] r3_a_rdata, r3_b_rdata;
    logic [10:0] s1_addr;
    logic [31:0] s1_din, dout1;
    logic        s1_we, s1_se;

    sram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_addr(s0_addr), .sram_din(s0_din), .sram_write_en(s0_we),
        .sram_sense_en(s0_se), .sram_dout(dout0), .busy(busy)
    );

    sram_port_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(r3_req), .a_we(1'b0), .a_addr(r3_addr), .a_wdata(32'h0),
        .a_gnt(r3_a_gnt), .a_rvalid(r3_a_rvalid), .a_rdata(r3_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(11'h0), .b_wdata(32'h0),
        .b_gnt(r3_b_gnt), .b_rvalid(r3_b_rvalid), .b_rdata(r3_b_rdata),
        .sram_addr(s1_addr), .sram_din(s1_din), .sram_write_en(s1_we),
        .sram_sense_en(s1_se), .sram_dout(dout1), .busy(r3_busy)
    );

    function automatic logic [31:0] pat(input logic [10:0] a);
        return 32'hA5A5_0000 | {21'h0, a};
    endfunction

    logic [31:0] mem0 [logic [10:0]];
    logic [31:0] mem1 [logic [10:0]];
    logic [31:0] d1_0, d1_1, d1_2;

    always @(posedge clk) begin
        if (s0_we) mem0[s0_addr] = s0_din;
        if (!s0_se) dout0 <= mem0.exists(s0_addr) ? mem0[s0_addr] : pat(s0_addr);
    end

    always @(posedge clk) begin
        if (s1_we) mem1[s1_addr] = s1_din;
        if (!s1_se) d1_0 <= mem1.exists(s1_addr) ? mem1[s1_addr] : pat(s1_addr);
        d1_1 <= d1_0;
        d1_2 <= d1_1;
    end
    assign dout1 = d1_2;

    typedef struct {
        logic        ar, aw;
        logic [10:0] aa;
        logic [31:0] ad;
        logic        br, bw;
        logic [10:0] ba;
        logic [31:0] bd;
        logic        eag, ebg;
        logic [1:0]  ecmd;
        logic [10:0] eca;
        logic        earv, ebrv;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t v(input logic ar, input logic aw, input logic [10:0] aa,
                               input logic [31:0] ad, input logic br, input logic bw,
                               input logic [10:0] ba, input logic [31:0] bd,
                               input logic eag, input logic ebg, input logic [1:0] ecmd,
                               input logic [10:0] eca, input logic earv, input logic ebrv,
                               input logic [31:0] erd);
        vec_t r;
        r.ar = ar; r.aw = aw; r.aa = aa; r.ad = ad;
        r.br = br; r.bw = bw; r.ba = ba; r.bd = bd;
        r.eag = eag; r.ebg = ebg; r.ecmd = ecmd; r.eca = eca;
        r.earv = earv; r.ebrv = ebrv; r.erd = erd;
        return r;
    endfunction

    function automatic vec_t vi(input logic earv, input logic ebrv, input logic [31:0] erd);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CI, 0, earv, ebrv, erd);
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // cycle table, one row per clock, starting from reset state (last_gnt = B)
        tbl.push_back(v(1,1,11'h005,32'hDEADBEEF, 0,0,0,0, 1,0,CW,11'h005, 0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(v(1,0,11'h005,0, 0,0,0,0, 1,0,CR,11'h005, 0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(1,0,32'hDEADBEEF));
        // turnaround: B read blocked in the cycle after A's write
        tbl.push_back(v(1,1,11'h010,32'h12345678, 0,0,0,0, 1,0,CW,11'h010, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,11'h010,0, 0,0,CI,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,11'h010,0, 0,1,CR,11'h010, 0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,1,32'h12345678));
        // both ports streaming reads of 0..3
        tbl.push_back(v(1,0,0,0, 1,0,0,0, 1,0,CR,0, 0,0,0));
        tbl.push_back(v(1,0,1,0, 1,0,0,0, 0,1,CR,0, 0,0,0));
        tbl.push_back(v(1,0,1,0, 1,0,1,0, 1,0,CR,1, 0,0,0));
        tbl.push_back(v(1,0,2,0, 1,0,1,0, 0,1,CR,1, 1,0,pat(0)));
        tbl.push_back(v(1,0,2,0, 1,0,2,0, 1,0,CR,2, 0,1,pat(0)));
        tbl.push_back(v(1,0,3,0, 1,0,2,0, 0,1,CR,2, 1,0,pat(1)));
        tbl.push_back(v(1,0,3,0, 1,0,3,0, 1,0,CR,3, 0,1,pat(1)));
        tbl.push_back(v(0,0,0,0, 1,0,3,0, 0,1,CR,3, 1,0,pat(2)));
        tbl.push_back(vi(0,1,pat(2)));
        tbl.push_back(vi(1,0,pat(3)));
        tbl.push_back(vi(0,1,pat(3)));
        // A write vs B read in WR: A wins although it was granted last
        tbl.push_back(v(1,1,11'h020,32'hCAFEF00D, 0,0,0,0, 1,0,CW,11'h020, 0,0,0));
        tbl.push_back(v(1,1,11'h021,32'h0BADF00D, 1,0,11'h020,0, 1,0,CW,11'h021, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,11'h020,0, 0,0,CI,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,11'h020,0, 0,1,CR,11'h020, 0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,1,32'hCAFEF00D));
        // simultaneous writes, then a read blocked by turnaround
        tbl.push_back(v(1,1,11'h030,32'h1, 1,1,11'h031,32'h2, 1,0,CW,11'h030, 0,0,0));
        tbl.push_back(v(0,0,0,0, 1,1,11'h031,32'h2, 0,1,CW,11'h031, 0,0,0));
        tbl.push_back(v(1,0,11'h031,0, 0,0,0,0, 0,0,CI,0, 0,0,0));
        tbl.push_back(v(1,0,11'h031,0, 0,0,0,0, 1,0,CR,11'h031, 0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(0,0,0));
        tbl.push_back(vi(1,0,32'h2));

        // reset with requests pending: grants must stay low
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = '0; b_wdata = '0;
        r3_req = 1'b0; r3_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_sense_en", s0_se, 1);
        chk("rst_write_en", s0_we, 0);
        chk("rst_addr", s0_addr, 0);
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_sense_en", s0_se, 1);
        chk("idle_write_en", s0_we, 0);
        chk("idle_gnt", {a_gnt, b_gnt}, 0);
        chk("idle_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rdata", a_rdata | b_rdata, 0);

        foreach (tbl[i]) begin
            a_req = tbl[i].ar; a_we = tbl[i].aw; a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
            b_req = tbl[i].br; b_we = tbl[i].bw; b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
            #1;
            chk($sformatf("row%0d a_gnt", i), a_gnt, tbl[i].eag);
            chk($sformatf("row%0d b_gnt", i), b_gnt, tbl[i].ebg);
            chk($sformatf("row%0d a_rvalid", i), a_rvalid, tbl[i].earv);
            chk($sformatf("row%0d b_rvalid", i), b_rvalid, tbl[i].ebrv);
            if (tbl[i].earv) chk($sformatf("row%0d a_rdata", i), a_rdata, tbl[i].erd);
            if (tbl[i].ebrv) chk($sformatf("row%0d b_rdata", i), b_rdata, tbl[i].erd);
            @(negedge clk);
            chk($sformatf("row%0d write_en", i), s0_we, tbl[i].ecmd == CW);
            chk($sformatf("row%0d sense_en", i), s0_se, tbl[i].ecmd != CR);
            if (tbl[i].ecmd != CI) chk($sformatf("row%0d sram_addr", i), s0_addr, tbl[i].eca);
            if (tbl[i].ecmd == CW)
                chk($sformatf("row%0d sram_din", i), s0_din, tbl[i].eag ? tbl[i].ad : tbl[i].bd);
        end
        chk("rdata_held_a", a_rdata, 32'h2);
        chk("rdata_held_b", b_rdata, 32'hCAFEF00D);

        // reset in the middle of three back-to-back B reads
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_addr = 11'(k + 1);
            #1 chk($sformatf("mid_b_gnt%0d", k), b_gnt, 1);
            @(negedge clk);
        end
        b_req = 1'b0;
        #1 chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_cleared", busy, 0);
        chk("mid_sense_en", s0_se, 1);
        chk("mid_rvalid", b_rvalid, 0);
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (b_rvalid || a_rvalid || busy) seen++;
                @(negedge clk);
            end
            chk("mid_no_rvalid_after_reset", seen, 0);
        end

        // RD_LAT = 3 single read
        r3_req = 1'b1; r3_addr = 11'h007;
        #1 chk("lat3_gnt", r3_a_gnt, 1);
        @(negedge clk);
        r3_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1 chk($sformatf("lat3_rvalid_T+%0d", k), r3_a_rvalid, k == 5);
            if (k == 5) chk("lat3_rdata", r3_a_rdata, pat(11'h007));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
